// File: rtl/leaf_sched_pkg.sv
// leaf_sched_pkg: BFT packet field layout and scheduler state encoding shared by leaf_out_sched
package leaf_sched_pkg;
  localparam int VALID_BIT = 48;
  localparam int LEAF_LSB = 43;
  localparam int PORT_LSB = 39;
  localparam int SEQ_LSB = 32;
  localparam int SEQ_BITS = 7;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
endpackage

// File: rtl/leaf_out_sched_rr_arbiter.sv
// rr_arbiter: N-way rotating-priority arbiter, one-hot grant searching upward from the bit after the previous grant
// Ports: req (request vector), last (previous one-hot grant), gnt (one-hot grant, 0 when no request)
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [N-1:0] last,
  output logic [N-1:0] gnt
);
  logic [N-1:0] above;
  logic [N-1:0] hi;
  // bits strictly above the previous grant win first; otherwise wrap to the lowest request
  assign above = ~((last << 1) - N'(1));
  assign hi = req & above;
  assign gnt = |hi ? hi & -hi : req & -req;
endmodule

// File: rtl/leaf_out_sched.sv
// leaf_out_sched: round-robin, credit-flow-controlled scheduler of user output streams onto one BFT output link
// Ports: din_user/vld_user/ack_user user streams; cfg_* per-port destination writes; credit_* credit returns;
//        resend pause mask; bft_ready/pkt_out registered BFT packet; stat_sel/stat_cnt per-port sent-word readout.
// Build option: define LEAF_OUT_SCHED_STATS_EN for per-port sent-word counters; otherwise stat_cnt is 0.
module leaf_out_sched
  import leaf_sched_pkg::*;
#(
  parameter int PACKET_BITS   = 49,
  parameter int PAYLOAD_BITS  = 32,
  parameter int NUM_LEAF_BITS = 5,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_OUT_PORTS = 4,
  parameter int CREDIT_BITS   = 8,
  parameter int INIT_CREDIT   = 128
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_user,
  input  logic [NUM_OUT_PORTS-1:0]                vld_user,
  output logic [NUM_OUT_PORTS-1:0]                ack_user,
  input  logic                                    cfg_we,
  input  logic [2:0]                              cfg_port,
  input  logic [NUM_LEAF_BITS+NUM_PORT_BITS-1:0]  cfg_dest,
  input  logic                                    credit_vld,
  input  logic [2:0]                              credit_port,
  input  logic [CREDIT_BITS-1:0]                  credit_inc,
  input  logic                                    resend,
  input  logic                                    bft_ready,
  output logic [PACKET_BITS-1:0]                  pkt_out,
  input  logic [2:0]                              stat_sel,
  output logic [31:0]                             stat_cnt
);
  localparam int N = NUM_OUT_PORTS;
  localparam int DEST_BITS = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam logic [CREDIT_BITS:0] CMAX = {1'b0, {CREDIT_BITS{1'b1}}};
  state_t state_q, state_d;
  logic [PACKET_BITS-1:0] pkt_q, pkt_d;
  logic [N-1:0] last_q, last_d, cfgd_q, cfgd_d, req, gnt;
  logic [DEST_BITS-1:0] dest_q [N];
  logic [DEST_BITS-1:0] dest_d [N];
  logic [CREDIT_BITS-1:0] credit_q [N];
  logic [CREDIT_BITS-1:0] credit_d [N];
  logic [SEQ_BITS-1:0] seq_q [N];
  logic [SEQ_BITS-1:0] seq_d [N];
  logic [CREDIT_BITS:0] sum;
  logic hold, load;
  // paused (or pausing this cycle): output masked, register frozen, no grants
  assign hold = resend || state_q == PAUSE;
  assign load = !hold && (!pkt_q[VALID_BIT] || bft_ready);
  assign pkt_out = hold ? '0 : pkt_q;
  assign ack_user = load ? gnt : '0;
  always_comb begin
    for (int i = 0; i < N; i++)
      req[i] = vld_user[i] && cfgd_q[i] && credit_q[i] != '0 && state_q == RUN;
  end
  rr_arbiter #(.N(N)) u_arb (
    .req  (req),
    .last (last_q),
    .gnt  (gnt)
  );
  always_comb begin
    state_d = state_q == IDLE ? (|cfgd_q ? RUN : IDLE) : (resend ? PAUSE : RUN);
    pkt_d = load ? '0 : pkt_q;
    last_d = |ack_user ? ack_user : last_q;
    cfgd_d = cfgd_q;
    sum = '0;
    for (int i = 0; i < N; i++) begin
      // returned credit and grant decrement combine before saturation
      sum = {1'b0, credit_q[i]} + ((credit_vld && credit_port == 3'(i)) ? {1'b0, credit_inc} : '0)
          - {{CREDIT_BITS{1'b0}}, ack_user[i]};
      if (ack_user[i]) pkt_d = {1'b1, dest_q[i], seq_q[i], din_user[i*PAYLOAD_BITS +: PAYLOAD_BITS]};
      dest_d[i] = dest_q[i];
      credit_d[i] = sum > CMAX ? CMAX[CREDIT_BITS-1:0] : sum[CREDIT_BITS-1:0];
      seq_d[i] = seq_q[i] + SEQ_BITS'(ack_user[i]);
      // a concurrent grant already used the old dest; config wins for credit and seq
      if (cfg_we && cfg_port == 3'(i)) begin
        dest_d[i] = cfg_dest;
        cfgd_d[i] = 1'b1;
        credit_d[i] = CREDIT_BITS'(INIT_CREDIT);
        seq_d[i] = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pkt_q <= '0;
      last_q <= N'(1) << (N - 1);
      cfgd_q <= '0;
      for (int i = 0; i < N; i++) begin
        dest_q[i] <= '0;
        credit_q[i] <= CREDIT_BITS'(INIT_CREDIT);
        seq_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pkt_q <= pkt_d;
      last_q <= last_d;
      cfgd_q <= cfgd_d;
      dest_q <= dest_d;
      credit_q <= credit_d;
      seq_q <= seq_d;
    end
  end
`ifdef LEAF_OUT_SCHED_STATS_EN
  logic [31:0] cnt_q [N];
  logic [31:0] cnt_d [N];
  logic [31:0] stat_q, stat_d;
  always_comb begin
    stat_d = '0;
    for (int i = 0; i < N; i++) begin
      cnt_d[i] = cnt_q[i] + 32'(ack_user[i]);
      if (stat_sel == 3'(i)) stat_d = cnt_q[i];
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_q <= '0;
      for (int i = 0; i < N; i++) cnt_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
      cnt_q <= cnt_d;
    end
  end
  assign stat_cnt = stat_q;
`else
  logic stat_unused;
  assign stat_unused = ^stat_sel;
  assign stat_cnt = '0;
`endif
endmodule

// File: tb/tb_leaf_out_sched.sv
// tb_leaf_out_sched: directed and randomized checks of leaf_out_sched against a cycle-level reference model
module tb_leaf_out_sched;
  import leaf_sched_pkg::*;
  localparam int N = 4;
  localparam int PB = 32;
  localparam int INIT = 8;
  localparam int CMAXI = 255;
  logic clk = 1'b0;
  logic reset;
  logic [N*PB-1:0] din_user;
  logic [N-1:0] vld_user, ack_user;
  logic cfg_we;
  logic [2:0] cfg_port;
  logic [8:0] cfg_dest;
  logic credit_vld;
  logic [2:0] credit_port;
  logic [7:0] credit_inc;
  logic resend, bft_ready;
  logic [48:0] pkt_out;
  logic [2:0] stat_sel;
  logic [31:0] stat_cnt;
  int vectors = 0;
  int errors = 0;
  int obs [N];
  logic [SEQ_BITS-1:0] seen [$];
  bit m_started, m_paused, m_full;
  logic [48:0] m_pkt;
  bit m_cfg [N];
  logic [8:0] m_dest [N];
  int m_credit [N];
  int m_seq [N];
  int m_last;
  logic [31:0] m_cnt [N];
  logic [31:0] m_stat;

  leaf_out_sched #(.INIT_CREDIT(INIT)) dut (
    .clk(clk), .reset(reset), .din_user(din_user), .vld_user(vld_user), .ack_user(ack_user),
    .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_dest(cfg_dest),
    .credit_vld(credit_vld), .credit_port(credit_port), .credit_inc(credit_inc),
    .resend(resend), .bft_ready(bft_ready), .pkt_out(pkt_out), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    din_user = '0; vld_user = '0; cfg_we = 0; cfg_port = 0; cfg_dest = 0;
    credit_vld = 0; credit_port = 0; credit_inc = 0; resend = 0; bft_ready = 1; stat_sel = 0;
  endtask

  task automatic rand_din();
    for (int i = 0; i < N; i++) din_user[i*PB +: PB] = $urandom;
  endtask

  task automatic model_reset();
    m_started = 0; m_paused = 0; m_full = 0; m_pkt = '0; m_last = N - 1; m_stat = '0;
    for (int i = 0; i < N; i++) begin
      m_cfg[i] = 0; m_dest[i] = '0; m_credit[i] = INIT; m_seq[i] = 0; m_cnt[i] = '0; obs[i] = 0;
    end
  endtask

  // one clock: compare outputs at the falling edge, then advance the model past the rising edge
  task automatic cycle();
    int g;
    bit hold, can_load, any_cfg;
    logic [N-1:0] exp_ack;
    logic [48:0] exp_pkt;
    logic [31:0] nstat;
    @(negedge clk);
    hold = resend || m_paused;
    can_load = !hold && (!m_full || bft_ready);
    exp_pkt = hold ? '0 : m_pkt;
    g = -1;
    if (can_load && m_started)
      for (int k = 1; k <= N; k++) begin
        int p;
        p = (m_last + k) % N;
        if (g < 0 && vld_user[p] && m_cfg[p] && m_credit[p] > 0) g = p;
      end
    exp_ack = '0;
    if (g >= 0) exp_ack[g] = 1'b1;
    vectors++;
    if (ack_user !== exp_ack) begin
      errors++; $display("FAIL ack_user @%0t: got %b want %b", $time, ack_user, exp_ack);
    end
    vectors++;
    if (pkt_out !== exp_pkt) begin
      errors++; $display("FAIL pkt_out @%0t: got %h want %h", $time, pkt_out, exp_pkt);
    end
    vectors++;
    if (stat_cnt !== m_stat) begin
      errors++; $display("FAIL stat_cnt @%0t: got %0d want %0d", $time, stat_cnt, m_stat);
    end
    for (int i = 0; i < N; i++) if (ack_user[i]) obs[i]++;
    if (pkt_out[VALID_BIT] && bft_ready) seen.push_back(pkt_out[SEQ_LSB +: SEQ_BITS]);
    any_cfg = 0;
    for (int i = 0; i < N; i++) any_cfg |= m_cfg[i];
    nstat = '0;
`ifdef LEAF_OUT_SCHED_STATS_EN
    if (stat_sel < N) nstat = m_cnt[stat_sel];
`endif
    if (can_load && g >= 0) begin
      m_pkt = {1'b1, m_dest[g], 7'(m_seq[g]), din_user[g*PB +: PB]};
      m_full = 1; m_seq[g] = (m_seq[g] + 1) % 128; m_credit[g]--; m_last = g; m_cnt[g]++;
    end else if (can_load) begin
      m_pkt = '0; m_full = 0;
    end
    if (credit_vld && credit_port < N) begin
      int c;
      c = m_credit[credit_port] + int'(credit_inc);
      m_credit[credit_port] = c > CMAXI ? CMAXI : c;
    end
    if (cfg_we && cfg_port < N) begin
      m_dest[cfg_port] = cfg_dest; m_cfg[cfg_port] = 1; m_credit[cfg_port] = INIT; m_seq[cfg_port] = 0;
    end
    if (!m_started) begin
      m_started = any_cfg; m_paused = 0;
    end else m_paused = resend;
    m_stat = nstat;
    @(posedge clk);
    #1;
  endtask

  task automatic configure(input int p, input logic [8:0] d);
    cfg_we = 1; cfg_port = 3'(p); cfg_dest = d;
    cycle();
    cfg_we = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (pkt_out !== '0 || ack_user !== '0 || stat_cnt !== '0) begin
      errors++; $display("FAIL reset_state: pkt %h ack %b stat %0d want all 0", pkt_out, ack_user, stat_cnt);
    end
    reset = 1;
    vld_user = '1;
    rand_din();
    repeat (3) cycle();
    idle_inputs();
  endtask

  task automatic test_single();
    logic [48:0] want;
    want = {1'b1, 5'd3, 4'd2, 7'd0, 32'hA5A5A5A5};
    configure(0, {5'd3, 4'd2});
    cycle();
    vld_user = 4'b0001;
    din_user[31:0] = 32'hA5A5A5A5;
    cycle();
    vld_user = '0;
    #1;
    vectors++;
    if (pkt_out !== want) begin
      errors++; $display("FAIL single_pkt: got %h want %h", pkt_out, want);
    end
    cycle();
  endtask

  task automatic test_round_robin();
    for (int i = 0; i < N; i++) configure(i, 9'(16 * i + 3));
    for (int i = 0; i < N; i++) obs[i] = 0;
    vld_user = '1; bft_ready = 1; credit_vld = 1; credit_inc = 1;
    for (int t = 0; t < 100; t++) begin
      rand_din();
      credit_port = 3'(t % N);
      cycle();
    end
    idle_inputs();
    for (int i = 0; i < N; i++) begin
      vectors++;
      if (obs[i] != 25) begin
        errors++; $display("FAIL rr_share port%0d: got %0d want 25", i, obs[i]);
      end
    end
    cycle();
  endtask

  task automatic test_credit();
    configure(1, 9'h055);
    for (int i = 0; i < N; i++) obs[i] = 0;
    vld_user = 4'b0010;
    repeat (12) begin rand_din(); cycle(); end
    vectors++;
    if (obs[1] != INIT) begin
      errors++; $display("FAIL credit_stall: got %0d grants want %0d", obs[1], INIT);
    end
    for (int i = 0; i < N; i++) obs[i] = 0;
    vld_user = 4'b0011;
    credit_vld = 1; credit_port = 1; credit_inc = 1;
    rand_din();
    cycle();
    credit_vld = 0;
    repeat (6) begin rand_din(); cycle(); end
    vectors++;
    if (obs[1] != 1) begin
      errors++; $display("FAIL credit_return: got %0d grants want 1", obs[1]);
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_backpressure();
    logic [48:0] saved;
    for (int i = 0; i < N; i++) configure(i, 9'(32 * i + 5));
    vld_user = '1;
    repeat (2) begin rand_din(); cycle(); end
    bft_ready = 0;
    #1;
    saved = pkt_out;
    for (int t = 0; t < 5; t++) begin
      rand_din();
      #1;
      vectors++;
      if (pkt_out !== saved || ack_user !== '0) begin
        errors++; $display("FAIL stall_hold: pkt %h ack %b want pkt %h ack 0", pkt_out, ack_user, saved);
      end
      cycle();
    end
    bft_ready = 1;
    #1;
    vectors++;
    if (ack_user === '0) begin
      errors++; $display("FAIL stall_resume: got ack %b want one grant", ack_user);
    end
    repeat (4) begin rand_din(); cycle(); end
  endtask

  task automatic test_resend();
    logic [48:0] saved;
    bit found;
    vld_user = '1; bft_ready = 1;
    repeat (3) begin rand_din(); cycle(); end
    saved = pkt_out;
    resend = 1;
    for (int t = 0; t < 3; t++) begin
      #1;
      vectors++;
      if (pkt_out !== '0 || ack_user !== '0) begin
        errors++; $display("FAIL resend_mask: pkt %h ack %b want 0", pkt_out, ack_user);
      end
      cycle();
    end
    resend = 0;
    found = 0;
    for (int t = 0; t < 4 && !found; t++) begin
      #1;
      if (pkt_out[VALID_BIT]) begin
        found = 1;
        vectors++;
        if (pkt_out !== saved) begin
          errors++; $display("FAIL resend_replay: got %h want %h", pkt_out, saved);
        end
      end else cycle();
    end
    vectors++;
    if (!found) begin
      errors++; $display("FAIL resend_timeout: held packet %h never reappeared", saved);
    end
    repeat (4) begin rand_din(); cycle(); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < N; i++) configure(i, 9'($urandom));
    for (int t = 0; t < 1500; t++) begin
      vld_user = N'($urandom);
      rand_din();
      bft_ready = $urandom_range(0, 3) != 0;
      resend = $urandom_range(0, 19) == 0;
      cfg_we = $urandom_range(0, 31) == 0;
      cfg_port = 3'($urandom);
      cfg_dest = 9'($urandom);
      credit_vld = $urandom_range(0, 2) == 0;
      credit_port = 3'($urandom);
      credit_inc = $urandom_range(0, 7) == 0 ? 8'($urandom) : 8'($urandom_range(0, 2));
      stat_sel = 3'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();
  endtask

  task automatic test_wrap();
    int guard;
    logic [31:0] want_stat;
    do_reset();
    configure(2, {5'd9, 4'd1});
    cycle();
    seen.delete();
    for (int i = 0; i < N; i++) obs[i] = 0;
    vld_user = 4'b0100; credit_vld = 1; credit_port = 2; credit_inc = 1;
    guard = 0;
    while (obs[2] < 130 && guard < 300) begin
      rand_din();
      cycle();
      guard++;
    end
    idle_inputs();
    stat_sel = 2;
    repeat (3) cycle();
    vectors++;
    if (obs[2] != 130) begin
      errors++; $display("FAIL wrap_grants: got %0d want 130", obs[2]);
    end
    vectors++;
    if (seen.size() != 130) begin
      errors++; $display("FAIL wrap_count: got %0d packets want 130", seen.size());
    end else begin
      vectors++;
      if (seen[127] !== 7'd127 || seen[128] !== 7'd0 || seen[129] !== 7'd1) begin
        errors++; $display("FAIL seq_wrap: got %0d,%0d,%0d want 127,0,1", seen[127], seen[128], seen[129]);
      end
    end
`ifdef LEAF_OUT_SCHED_STATS_EN
    want_stat = 32'd130;
`else
    want_stat = 32'd0;
`endif
    vectors++;
    if (stat_cnt !== want_stat) begin
      errors++; $display("FAIL stat_port2: got %0d want %0d", stat_cnt, want_stat);
    end
  endtask

  task automatic test_reset_mid();
    vld_user = 4'b0100; bft_ready = 0;
    rand_din();
    repeat (2) cycle();
    vectors++;
    if (pkt_out[VALID_BIT] !== 1'b1) begin
      errors++; $display("FAIL midreset_setup: got valid %b want 1", pkt_out[VALID_BIT]);
    end
    reset = 0;
    #1;
    vectors++;
    if (pkt_out !== '0 || ack_user !== '0) begin
      errors++; $display("FAIL midreset_drop: pkt %h ack %b want 0", pkt_out, ack_user);
    end
    @(posedge clk);
    #1;
    idle_inputs();
    reset = 1;
    model_reset();
    repeat (2) cycle();
  endtask

  initial begin
    idle_inputs();
    reset = 0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_credit();
    test_backpressure();
    test_resend();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
